farm_cpu: RTL and testbench
===========================

Name: farm_cpu

Overview:
- Multi-cycle RV32I-subset processor core: top level of the FARM design.
- Contains on-chip instruction memory, fetch unit, decode/register file, execute/ALU and a control-generator FSM.
- Exposes the current instruction and the PC of that instruction for debug and monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ins  output  32  current instruction register (IR).
- ret_ad  output  32  PC of the instruction held in IR (PC_temp).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, PC=RESET_PC, PC_temp=0.
  - IR=32'h0000_0013 (NOP), so ins=32'h13 and ret_ad=0.
  - All 32 registers cleared.
  - Imem contents untouched.
- FSM, 4 cycles per instruction, cycling FETCH->DECODE->EXECUTE->WRITEBACK->FETCH:
  - FETCH: IR<=imem[PC[log2(IMEM_DEPTH)+1:2]] (combinational read); PC_temp<=PC.
  - DECODE: latch A=x[rs1], B=x[rs2] and the sign-extended immediate (I/S/B/U/J formats).
  - EXECUTE: ALU result latched; branch condition evaluated; next-PC computed.
  - WRITEBACK: rd written if the instruction writes and rd!=0; PC<=next-PC.
- Next-PC rules:
  - Default: PC_temp+4.
  - JAL: PC_temp+immJ.
  - JALR: (x[rs1]+immI) with bits[1:0] forced to 0.
  - Taken branch: PC_temp+immB.
  - All target bits[1:0] forced 0.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LUI, AUIPC.
  - JAL, JALR (rd<=PC_temp+4).
  - BEQ, BNE, BLT, BGE.
- Any other opcode or funct: executes as NOP (no register write, PC+4).
- Arithmetic: 32-bit, modulo 2^32, no overflow trap; shift amount is bits[4:0].
- Register file:
  - 32x32, two combinational read ports, one write port.
  - x0 reads 0 always; writes to x0 ignored.
  - Simultaneous read/write of the same register in one cycle returns the old value (write lands at the edge).
- Imem:
  - Word-addressed.
  - Address wraps modulo IMEM_DEPTH.
  - No write port; preloaded by simulation hex file.
- Reset asserted mid-instruction: aborts immediately; no partial register write is committed.
- Debug hierarchy (fixed instance names for bench access):
  - cg.state: FSM state.
  - farm_fetch.iag.PC and farm_fetch.IR.
  - farm_pmi.imem.mem: word array [0:IMEM_DEPTH-1].
  - farm_dec.RF: register file, with task dump(first,last) printing "x<i> = <hex>" for each i in first..last inclusive.

Decomposition:
- Package farm_pkg:
  - State enum (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Opcode constants (OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR).
  - ALU-op enum.
  - NOP constant.
- Natural sub-module: farm_regfile (the RF instance) with the dump task.
- Fetch, decode and control may be thin wrappers within the same file set.

Test Plan:
- Hold rst_n=0 for 2 cycles -> state=FETCH, PC=0, ins=32'h13, ret_ad=0; after release, first FETCH edge gives ins=imem[0] and ret_ad=0.
- Program "addi x1,x0,5; addi x2,x1,7; add x3,x1,x2; sub x4,x2,x1", run 16 cycles, then dump(0,10) -> x1=5, x2=12, x3=17, x4=7, others 0.
- "jal x5,8" at address 0x0 -> x5=4; the next fetch has ret_ad=0x8; the instruction at 0x4 is skipped.
- "addi x1,x0,3; addi x2,x0,3; beq x1,x2,8" at 0x8 -> next ret_ad=0x10. Repeat with bne -> next ret_ad=0xC.
- "addi x0,x0,9" -> x0 dumps 0; "jalr x6,0(x5)" with x5=0x0D -> PC=0x0C, x6=return address.
- Assert rst_n=0 during EXECUTE of "addi x7,x0,1" -> x7 stays 0; PC=0, state=FETCH asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/farm_pkg.sv
// Shared types, opcode constants and decode helpers for the FARM RV32I-subset core.
package farm_pkg;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_e;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_ST    = 7'h23;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_LINK, WB_IMM, WB_AUIPC} wb_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    wr;
    wb_sel_e wb_sel;
    logic    jal;
    logic    jalr;
    logic    br;
  } ctrl_t;

  // Unsupported opcodes/functs fall out as a zeroed ctrl: no write, no jump, PC+4.
  function automatic ctrl_t decode_ctrl(input logic [31:0] ir);
    ctrl_t c;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    c = '{alu_op: ALU_ADD, use_imm: 1'b0, wr: 1'b0, wb_sel: WB_ALU,
          jal: 1'b0, jalr: 1'b0, br: 1'b0};
    case (ir[6:0])
      OP_R: begin
        c.wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: c.alu_op = ALU_ADD;
          {7'h20, 3'd0}: c.alu_op = ALU_SUB;
          {7'h00, 3'd1}: c.alu_op = ALU_SLL;
          {7'h00, 3'd2}: c.alu_op = ALU_SLT;
          {7'h00, 3'd3}: c.alu_op = ALU_SLTU;
          {7'h00, 3'd4}: c.alu_op = ALU_XOR;
          {7'h00, 3'd5}: c.alu_op = ALU_SRL;
          {7'h20, 3'd5}: c.alu_op = ALU_SRA;
          {7'h00, 3'd6}: c.alu_op = ALU_OR;
          {7'h00, 3'd7}: c.alu_op = ALU_AND;
          default:       c.wr = 1'b0;
        endcase
      end
      OP_I: begin
        c.wr      = 1'b1;
        c.use_imm = 1'b1;
        case (f3)
          3'd0: c.alu_op = ALU_ADD;
          3'd2: c.alu_op = ALU_SLT;
          3'd4: c.alu_op = ALU_XOR;
          3'd6: c.alu_op = ALU_OR;
          3'd7: c.alu_op = ALU_AND;
          3'd1: begin
            if (f7 == 7'h00) c.alu_op = ALU_SLL;
            else             c.wr = 1'b0;
          end
          3'd5: begin
            if (f7 == 7'h00)      c.alu_op = ALU_SRL;
            else if (f7 == 7'h20) c.alu_op = ALU_SRA;
            else                  c.wr = 1'b0;
          end
          default: c.wr = 1'b0;
        endcase
      end
      OP_LUI: begin
        c.wr     = 1'b1;
        c.wb_sel = WB_IMM;
      end
      OP_AUIPC: begin
        c.wr     = 1'b1;
        c.wb_sel = WB_AUIPC;
      end
      OP_JAL: begin
        c.wr     = 1'b1;
        c.wb_sel = WB_LINK;
        c.jal    = 1'b1;
      end
      OP_JALR: begin
        if (f3 == 3'd0) begin
          c.wr      = 1'b1;
          c.wb_sel  = WB_LINK;
          c.jalr    = 1'b1;
          c.use_imm = 1'b1;
        end
      end
      OP_BR: begin
        c.br = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_I, OP_JALR:    imm = {{20{ir[31]}}, ir[31:20]};
      OP_ST:            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:            imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {ir[31:12], 12'h000};
      OP_JAL:           imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/farm_ctrl.sv
// Control generator: free-running four-phase instruction sequencer.
//   state     | meaning
//   FETCH     | IR and PC_temp capture imem[PC]
//   DECODE    | operands and immediate latched from the register file
//   EXECUTE   | ALU result, branch decision and next PC latched
//   WRITEBACK | rd committed, PC advanced
module farm_ctrl
  import farm_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  output state_e state_o
);

  state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:     state <= DECODE;
        DECODE:    state <= EXECUTE;
        EXECUTE:   state <= WRITEBACK;
        default:   state <= FETCH;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: rtl/farm_dec.sv
// Decode stage: register file plus the operand and immediate latches.
module farm_dec
  import farm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  state_e      state_i,
  input  logic [31:0] ir_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] imm_o
);

  logic [31:0] rd1, rd2;
  logic [31:0] a_q, b_q, imm_q;

  farm_regfile RF (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (ir_i[19:15]),
    .ra2_i (ir_i[24:20]),
    .wa_i  (ir_i[11:7]),
    .we_i  (we_i),
    .wd_i  (wd_i),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      imm_q <= 32'h0;
    end else if (state_i == DECODE) begin
      a_q   <= rd1;
      b_q   <= rd2;
      imm_q <= imm_gen(ir_i);
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign imm_o = imm_q;

endmodule

// File: rtl/farm_exe.sv
// Execute stage: ALU, branch compare and next-PC selection, all latched in EXECUTE.
module farm_exe
  import farm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  state_e      state_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc_temp_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] imm_i,
  output logic [31:0] result_o,
  output logic [31:0] next_pc_o,
  output logic        wr_o
);

  ctrl_t       ctrl;
  logic [31:0] op_b, alu, result_d, target;
  logic        taken;
  logic [31:0] result_q, next_pc_q;
  logic        wr_q;

  assign ctrl = decode_ctrl(ir_i);
  assign op_b = ctrl.use_imm ? imm_i : b_i;

  always_comb begin
    alu = 32'h0;
    case (ctrl.alu_op)
      ALU_ADD:  alu = a_i + op_b;
      ALU_SUB:  alu = a_i - op_b;
      ALU_AND:  alu = a_i & op_b;
      ALU_OR:   alu = a_i | op_b;
      ALU_XOR:  alu = a_i ^ op_b;
      ALU_SLT:  alu = {31'h0, $signed(a_i) < $signed(op_b)};
      ALU_SLTU: alu = {31'h0, a_i < op_b};
      ALU_SLL:  alu = a_i << op_b[4:0];
      ALU_SRL:  alu = a_i >> op_b[4:0];
      ALU_SRA:  alu = $signed(a_i) >>> op_b[4:0];
      default:  alu = 32'h0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (ir_i[14:12])
      3'd0:    taken = (a_i == b_i);
      3'd1:    taken = (a_i != b_i);
      3'd4:    taken = $signed(a_i) < $signed(b_i);
      3'd5:    taken = $signed(a_i) >= $signed(b_i);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = pc_temp_i + 32'd4;
    if (ctrl.jal)                 target = pc_temp_i + imm_i;
    else if (ctrl.jalr)           target = alu;
    else if (ctrl.br && taken)    target = pc_temp_i + imm_i;
  end

  always_comb begin
    result_d = alu;
    case (ctrl.wb_sel)
      WB_LINK:  result_d = pc_temp_i + 32'd4;
      WB_IMM:   result_d = imm_i;
      WB_AUIPC: result_d = pc_temp_i + imm_i;
      default:  result_d = alu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= 32'h0;
      next_pc_q <= 32'h0;
      wr_q      <= 1'b0;
    end else if (state_i == EXECUTE) begin
      result_q  <= result_d;
      next_pc_q <= {target[31:2], 2'b00};
      wr_q      <= ctrl.wr;
    end
  end

  assign result_o  = result_q;
  assign next_pc_o = next_pc_q;
  assign wr_o      = wr_q;

endmodule

// File: rtl/farm_fetch.sv
// Fetch unit: PC generator plus the instruction register and its PC tag.
module farm_fetch
  import farm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  state_e      state_i,
  input  logic [31:0] imem_rdata_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic [31:0] pc_temp_o
);

  logic [31:0] IR;
  logic [31:0] PC_temp;
  logic [31:0] pc;

  farm_iag #(.RESET_PC(RESET_PC)) iag (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_i == WRITEBACK),
    .next_pc_i (next_pc_i),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR      <= NOP;
      PC_temp <= 32'h0;
    end else if (state_i == FETCH) begin
      IR      <= imem_rdata_i;
      PC_temp <= pc;
    end
  end

  assign pc_o      = pc;
  assign ir_o      = IR;
  assign pc_temp_o = PC_temp;

endmodule

// File: rtl/farm_iag.sv
// Instruction address generator: holds PC, advances once per instruction.
module farm_iag #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      PC <= RESET_PC;
    else if (load_i) PC <= next_pc_i;
  end

  assign pc_o = PC;

endmodule

// File: rtl/farm_imem.sv
// Instruction ROM; contents are loaded from outside by the simulation environment.
module farm_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [0:DEPTH-1];

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/farm_pmi.sv
// Program memory interface: word address in, instruction out.
module farm_pmi #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);

  farm_imem #(.DEPTH(DEPTH), .AW(AW)) imem (
    .addr_i  (addr_i),
    .rdata_o (rdata_o)
  );

endmodule

// File: rtl/farm_regfile.sv
// 32x32 register file: two async read ports, one write port landing at the edge.
module farm_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs[ra2_i];

  task automatic dump(input int first, input int last);
    for (int i = first; i <= last; i++) $display("x%0d = %h", i, regs[i]);
  endtask

endmodule

// File: rtl/farm_cpu.sv
// FARM top: multi-cycle RV32I-subset core with on-chip instruction memory.
module farm_cpu
  import farm_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ins,
  output logic [31:0] ret_ad
);

  localparam int AW = $clog2(IMEM_DEPTH);

  state_e      state;
  logic [31:0] pc, ir, pc_temp, imem_rdata;
  logic [31:0] a, b, imm, result, next_pc;
  logic        wr;

  farm_ctrl cg (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (state)
  );

  farm_fetch #(.RESET_PC(RESET_PC)) farm_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .state_i      (state),
    .imem_rdata_i (imem_rdata),
    .next_pc_i    (next_pc),
    .pc_o         (pc),
    .ir_o         (ir),
    .pc_temp_o    (pc_temp)
  );

  farm_pmi #(.DEPTH(IMEM_DEPTH), .AW(AW)) farm_pmi (
    .addr_i  (pc[AW+1:2]),
    .rdata_o (imem_rdata)
  );

  // The register write is qualified by WRITEBACK so an aborted instruction never commits.
  farm_dec farm_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_i (state),
    .ir_i    (ir),
    .we_i    (wr && (state == WRITEBACK)),
    .wd_i    (result),
    .a_o     (a),
    .b_o     (b),
    .imm_o   (imm)
  );

  farm_exe farm_exe (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_i   (state),
    .ir_i      (ir),
    .pc_temp_i (pc_temp),
    .a_i       (a),
    .b_i       (b),
    .imm_i     (imm),
    .result_o  (result),
    .next_pc_o (next_pc),
    .wr_o      (wr)
  );

  assign ins    = ir;
  assign ret_ad = pc_temp;

endmodule

// File: tb/tb_farm_cpu.sv
// Directed-vector bench for farm_cpu: small programs loaded into imem, results checked per task.
module tb_farm_cpu;
  import farm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] ins;
  logic [31:0] ret_ad;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] prog [$];

  farm_cpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ins    (ins),
    .ret_ad (ret_ad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h67};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] xr(input int i);
    return dut.farm_dec.RF.regs[i];
  endfunction

  task automatic load_and_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) dut.farm_pmi.imem.mem[i] = NOP;
    foreach (prog[i]) dut.farm_pmi.imem.mem[i] = prog[i];
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1), enc_i(12'd7, 5'd1, 3'd0, 5'd2)};
    load_and_reset();
    vectors++;
    if (dut.cg.state !== FETCH) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.cg.state, FETCH);
    end
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want %h", dut.farm_fetch.iag.PC, 32'h0);
    end
    vectors++;
    if (ins !== 32'h13) begin
      errors++; $display("FAIL reset_ins: got %h want %h", ins, 32'h13);
    end
    vectors++;
    if (ret_ad !== 32'h0) begin
      errors++; $display("FAIL reset_ret_ad: got %h want %h", ret_ad, 32'h0);
    end
    release_reset();
    step(1);
    vectors++;
    if (ins !== 32'h0050_0093) begin
      errors++; $display("FAIL first_fetch_ins: got %h want %h", ins, 32'h0050_0093);
    end
    vectors++;
    if (ret_ad !== 32'h0) begin
      errors++; $display("FAIL first_fetch_ret_ad: got %h want %h", ret_ad, 32'h0);
    end
    step(1);
    vectors++;
    if (dut.cg.state !== EXECUTE) begin
      errors++; $display("FAIL state_sequence: got %0d want %0d", dut.cg.state, EXECUTE);
    end
  endtask

  task automatic test_arith();
    logic [31:0] exp [0:10];
    exp = '{32'd0, 32'd5, 32'd12, 32'd17, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1), enc_i(12'd7, 5'd1, 3'd0, 5'd2),
            enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4)};
    load_and_reset();
    release_reset();
    step(16);
    dut.farm_dec.RF.dump(0, 10);
    for (int i = 0; i <= 10; i++) begin
      vectors++;
      if (xr(i) !== exp[i]) begin
        errors++; $display("FAIL arith_x%0d: got %h want %h", i, xr(i), exp[i]);
      end
    end
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'h10) begin
      errors++; $display("FAIL arith_pc: got %h want %h", dut.farm_fetch.iag.PC, 32'h10);
    end
  endtask

  task automatic test_jal();
    prog = {enc_j(21'd8, 5'd5), enc_i(12'd1, 5'd0, 3'd0, 5'd9), enc_i(12'd2, 5'd0, 3'd0, 5'd10)};
    load_and_reset();
    release_reset();
    step(4);
    vectors++;
    if (xr(5) !== 32'h4) begin
      errors++; $display("FAIL jal_link: got %h want %h", xr(5), 32'h4);
    end
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'h8) begin
      errors++; $display("FAIL jal_pc: got %h want %h", dut.farm_fetch.iag.PC, 32'h8);
    end
    step(1);
    vectors++;
    if (ret_ad !== 32'h8) begin
      errors++; $display("FAIL jal_ret_ad: got %h want %h", ret_ad, 32'h8);
    end
    vectors++;
    if (ins !== 32'h0020_0513) begin
      errors++; $display("FAIL jal_target_ins: got %h want %h", ins, 32'h0020_0513);
    end
    step(3);
    vectors++;
    if (xr(9) !== 32'h0 || xr(10) !== 32'h2) begin
      errors++; $display("FAIL jal_skip: got x9=%h x10=%h want x9=0 x10=2", xr(9), xr(10));
    end
  endtask

  task automatic test_branch(input string name, input logic [2:0] f3, input logic [11:0] v1,
                             input logic [11:0] v2, input logic [31:0] exp_ret);
    prog = {enc_i(v1, 5'd0, 3'd0, 5'd1), enc_i(v2, 5'd0, 3'd0, 5'd2),
            enc_b(13'd8, 5'd2, 5'd1, f3)};
    load_and_reset();
    release_reset();
    step(13);
    vectors++;
    if (ret_ad !== exp_ret) begin
      errors++; $display("FAIL branch_%s: got ret_ad %h want %h", name, ret_ad, exp_ret);
    end
  endtask

  task automatic test_x0_jalr();
    prog = {enc_i(12'd9, 5'd0, 3'd0, 5'd0), enc_i(12'd13, 5'd0, 3'd0, 5'd5),
            enc_jalr(12'd0, 5'd5, 5'd6), enc_jalr(12'd33, 5'd5, 5'd7)};
    load_and_reset();
    release_reset();
    step(12);
    dut.farm_dec.RF.dump(0, 7);
    vectors++;
    if (xr(0) !== 32'h0) begin
      errors++; $display("FAIL x0_write: got %h want %h", xr(0), 32'h0);
    end
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'hC || xr(6) !== 32'hC) begin
      errors++; $display("FAIL jalr_aligned: got pc=%h x6=%h want pc=0000000c x6=0000000c",
                         dut.farm_fetch.iag.PC, xr(6));
    end
    step(4);
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'h2C || xr(7) !== 32'h10) begin
      errors++; $display("FAIL jalr_offset: got pc=%h x7=%h want pc=0000002c x7=00000010",
                         dut.farm_fetch.iag.PC, xr(7));
    end
  endtask

  task automatic test_alu_misc();
    logic [31:0] exp [1:19];
    prog = {enc_u(20'h80000, 5'd1, 7'h37),             // lui  x1
            enc_i(12'hFF8, 5'd0, 3'd0, 5'd2),          // addi x2,x0,-8
            enc_i(12'h404, 5'd1, 3'd5, 5'd3),          // srai x3,x1,4
            enc_i(12'h004, 5'd1, 3'd5, 5'd4),          // srli x4,x1,4
            enc_r(7'h00, 5'd0, 5'd2, 3'd2, 5'd5),      // slt  x5,x2,x0
            enc_r(7'h00, 5'd0, 5'd2, 3'd3, 5'd6),      // sltu x6,x2,x0
            enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd7),      // xor  x7,x1,x2
            enc_u(20'h00001, 5'd8, 7'h17),             // auipc x8,1 at 0x1c
            enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd9),      // add  x9,x1,x1
            enc_i(12'd33, 5'd0, 3'd0, 5'd11),          // addi x11,x0,33
            enc_r(7'h00, 5'd11, 5'd2, 3'd1, 5'd10),    // sll  x10,x2,x11
            enc_i(12'h0F0, 5'd2, 3'd7, 5'd12),         // andi x12,x2,0xf0
            enc_i(12'hFFF, 5'd0, 3'd6, 5'd13),         // ori  x13,x0,-1
            enc_i(12'd1, 5'd0, 3'd3, 5'd14),           // sltiu (unsupported)
            enc_r(7'h00, 5'd5, 5'd1, 3'd6, 5'd15),     // or   x15,x1,x5
            enc_r(7'h00, 5'd12, 5'd2, 3'd7, 5'd16),    // and  x16,x2,x12
            enc_r(7'h20, 5'd5, 5'd1, 3'd5, 5'd17),     // sra  x17,x1,x5
            enc_r(7'h00, 5'd5, 5'd1, 3'd5, 5'd18),     // srl  x18,x1,x5
            enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd19)};    // mul (unsupported)
    exp = '{32'h8000_0000, 32'hFFFF_FFF8, 32'hF800_0000, 32'h0800_0000, 32'h1,
            32'h0, 32'h7FFF_FFF8, 32'h0000_101C, 32'h0, 32'hFFFF_FFF0,
            32'd33, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h0, 32'h8000_0001,
            32'h0000_00F0, 32'hC000_0000, 32'h4000_0000, 32'h0};
    load_and_reset();
    release_reset();
    step(76);
    for (int i = 1; i <= 19; i++) begin
      vectors++;
      if (xr(i) !== exp[i]) begin
        errors++; $display("FAIL alu_x%0d: got %h want %h", i, xr(i), exp[i]);
      end
    end
    vectors++;
    if (dut.farm_fetch.iag.PC !== 32'h4C) begin
      errors++; $display("FAIL alu_pc: got %h want %h", dut.farm_fetch.iag.PC, 32'h4C);
    end
  endtask

  task automatic test_reset_mid();
    prog = {NOP, enc_i(12'd1, 5'd0, 3'd0, 5'd7)};
    load_and_reset();
    release_reset();
    step(6);
    vectors++;
    if (dut.cg.state !== EXECUTE || ret_ad !== 32'h4) begin
      errors++; $display("FAIL mid_setup: got state=%0d ret_ad=%h want state=2 ret_ad=00000004",
                         dut.cg.state, ret_ad);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dut.cg.state !== FETCH || dut.farm_fetch.iag.PC !== 32'h0) begin
      errors++; $display("FAIL mid_async: got state=%0d pc=%h want state=0 pc=00000000",
                         dut.cg.state, dut.farm_fetch.iag.PC);
    end
    vectors++;
    if (ins !== 32'h13 || ret_ad !== 32'h0) begin
      errors++; $display("FAIL mid_async_ir: got ins=%h ret_ad=%h want ins=00000013 ret_ad=0",
                         ins, ret_ad);
    end
    step(2);
    vectors++;
    if (xr(7) !== 32'h0) begin
      errors++; $display("FAIL mid_no_commit: got %h want %h", xr(7), 32'h0);
    end
    release_reset();
    step(8);
    vectors++;
    if (xr(7) !== 32'h1) begin
      errors++; $display("FAIL mid_recover: got %h want %h", xr(7), 32'h1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_arith();
    test_jal();
    test_branch("beq_taken",    3'd0, 12'd3,   12'd3, 32'h10);
    test_branch("bne_not",      3'd1, 12'd3,   12'd3, 32'h0C);
    test_branch("blt_signed",   3'd4, 12'hFFF, 12'd1, 32'h10);
    test_branch("bge_signed",   3'd5, 12'hFFF, 12'd1, 32'h0C);
    test_branch("bge_equal",    3'd5, 12'd3,   12'd3, 32'h10);
    test_branch("bltu_unsupp",  3'd6, 12'd1,   12'd3, 32'h0C);
    test_x0_jalr();
    test_alu_misc();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
